// File: rtl/detect_seq_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
// The helpers build the KMP next-state table from the pattern. They are only
// ever called with constant arguments, so they add no runtime logic.
package detect_seq_pkg;

    localparam int W_MAX = 32;

    // Returns the state reached from Sk after consuming bit b.
    // The pattern is read MSB first: the MSB-first index m maps to pattern[w-1-m].
    // Let s be the first k pattern bits followed by b. The result is the longest
    // pattern prefix that is also a suffix of s. That value is k+1 on a straight match.
    function automatic int kmp_next(input logic [W_MAX-1:0] pattern, input int w,
                                    input int k, input logic b);
        int   res;
        int   m;
        logic ok;
        logic sb;
        res = 0;
        for (int j = ((k + 1 < w) ? k + 1 : w); j >= 1; j--) begin
            if (res == 0) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    m  = k + 1 - j + i;
                    sb = (m < k) ? pattern[w-1-m] : b;
                    if (sb != pattern[w-1-i]) ok = 1'b0;
                end
                if (ok) res = j;
            end
        end
        return res;
    endfunction

    // Returns the longest proper border of the full pattern, that is, the longest
    // prefix that is also a suffix. Used as the restart point after a match when
    // overlapping detection is enabled.
    function automatic int border_len(input logic [W_MAX-1:0] pattern, input int w);
        int   res;
        logic ok;
        res = 0;
        for (int f = w - 1; f >= 1; f--) begin
            if (res == 0) begin
                ok = 1'b1;
                for (int i = 0; i < f; i++) begin
                    if (pattern[w-1-i] != pattern[f-1-i]) ok = 1'b0;
                end
                if (ok) res = f;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/detect_seq_counter.sv
// Saturating match counter. The clear input has priority over increment.
module detect_seq_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count up on each increment and hold once the counter is all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/detect_n_bit_sequence_using_fsm.sv
// Parametrised W-bit serial sequence detector with a Moore "detected" flag.
// The next-state table is a constant built at elaboration from the KMP helpers.
// Optional feature: define DETECT_SEQ_MATCH_COUNTER_EN to build the saturating
// match counter. When it is undefined, match_count is tied to zero.
//
//  state | meaning
//  S0    | no useful prefix seen
//  Sk    | last k consumed bits equal the first k pattern bits
//  SW    | full pattern seen (detected = 1)
module detect_n_bit_sequence_using_fsm
    import detect_seq_pkg::*;
#(
    parameter int               W       = 6,
    parameter logic [W_MAX-1:0] PATTERN = W_MAX'(6'b110011),
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             valid,
    input  logic             clear,
    output logic             detected,
    output logic [CNT_W-1:0] match_count
);

    localparam int SB = $clog2(W + 1);
    localparam int NS = 1 << SB;

    if (W < 2 || W > W_MAX) begin : g_bad_w
        $error("detect_n_bit_sequence_using_fsm: W must be in 2..32");
    end
    if ((PATTERN >> W) != '0) begin : g_bad_pattern
        $error("detect_n_bit_sequence_using_fsm: PATTERN wider than W");
    end

    logic [SB-1:0] r_state;
    logic [SB-1:0] w_next;
    logic [SB-1:0] w_nxt0 [0:NS-1];
    logic [SB-1:0] w_nxt1 [0:NS-1];

    // Constant next-state table. SW first falls back to the pattern border
    // (overlapping) or to S0 (non-overlapping), then the normal rule applies.
    // Codes above W are unreachable and map to S0.
    for (genvar k = 0; k < NS; k++) begin : g_tbl
        if (k <= W) begin : g_live
            localparam int KE = (k == W) ? (OVERLAP ? border_len(PATTERN, W) : 0) : k;
            assign w_nxt0[k] = SB'(kmp_next(PATTERN, W, KE, 1'b0));
            assign w_nxt1[k] = SB'(kmp_next(PATTERN, W, KE, 1'b1));
        end else begin : g_dead
            assign w_nxt0[k] = '0;
            assign w_nxt1[k] = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= '0;
        else     r_state <= w_next;
    end

    // Next state: clear wins, otherwise look up the table on a valid bit.
    always_comb begin
        w_next = r_state;
        if (clear)      w_next = '0;
        else if (valid) w_next = a ? w_nxt1[r_state] : w_nxt0[r_state];
    end

    assign detected = (r_state == SB'(W));

`ifdef DETECT_SEQ_MATCH_COUNTER_EN
    logic w_inc;

    // Each valid bit that lands in SW is one match, including SW -> SW when
    // the pattern overlaps itself.
    always_comb begin
        w_inc = valid && !clear && (w_next == SB'(W));
    end

    detect_seq_counter #(.CNT_W(CNT_W)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_inc),
        .i_clr   (clear),
        .o_count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule
